cic_decimator: RTL and testbench



---
 rtl/cic_pkg.sv | 26 ++
 rtl/cic_channel.sv | 80 ++++++++
 rtl/cic_decimator.sv | 85 ++++++++
 tb/tb_cic_decimator.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
//------------------------------------------------------------------------------
// Module  : cic_pkg
// Brief   : Shared helpers for the CIC decimator (clog2, accumulator width).
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package cic_pkg;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            width = width + 1;
        end
        return width;
    endfunction

    // Bit growth of an N-stage, M=1 CIC is N*log2(R); no guard bits beyond that.
    function automatic int acc_width(input int iwidth, input int n_stages, input int decim);
        return iwidth + n_stages * clog2(decim);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cic_channel.sv
//------------------------------------------------------------------------------
// Module  : cic_channel
// Brief   : One CIC lane: registered integrator chain, strobed comb chain,
//           truncating output register.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cic_channel
    import cic_pkg::*;
#(
    parameter int IWIDTH   = 17,
    parameter int OWIDTH   = 16,
    parameter int N_STAGES = 3,
    parameter int DECIM    = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic              strobe,
    input  logic [IWIDTH-1:0] sample,
    output logic [OWIDTH-1:0] dout
);

    localparam int C_ACC_W = acc_width(IWIDTH, N_STAGES, DECIM);
    localparam int C_SHIFT = C_ACC_W - OWIDTH;

    logic [C_ACC_W-1:0] integ_q [N_STAGES];
    logic [C_ACC_W-1:0] integ_d [N_STAGES];
    logic [C_ACC_W-1:0] dly_q   [N_STAGES];
    logic [C_ACC_W-1:0] dly_d   [N_STAGES];
    logic [OWIDTH-1:0]  dout_q;
    logic [OWIDTH-1:0]  dout_d;
    logic [C_ACC_W-1:0] w_comb;

    // All arithmetic is intentionally modulo 2^C_ACC_W; wrap-around cancels in the combs.
    always_comb begin
        integ_d = integ_q;
        dly_d   = dly_q;
        dout_d  = dout_q;
        w_comb  = integ_q[N_STAGES-1];

        if (clk_en) begin
            integ_d[0] = integ_q[0] + {{(C_ACC_W-IWIDTH){sample[IWIDTH-1]}}, sample};
            for (int k = 1; k < N_STAGES; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
        end

        for (int k = 0; k < N_STAGES; k++) begin
            if (strobe) begin
                dly_d[k] = w_comb;
            end
            w_comb = w_comb - dly_q[k];
        end

        if (strobe) begin
            dout_d = OWIDTH'(w_comb >> C_SHIFT);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int k = 0; k < N_STAGES; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
            dout_q <= '0;
        end else begin
            integ_q <= integ_d;
            dly_q   <= dly_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

`default_nettype wire

// File: rtl/cic_decimator.sv
//------------------------------------------------------------------------------
// Module  : cic_decimator
// Brief   : Dual-channel (I/Q) CIC decimator; shared decimation counter and
//           output-valid strobe driving two cic_channel lanes.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cic_decimator
    import cic_pkg::*;
#(
    parameter int IWIDTH   = 17,
    parameter int OWIDTH   = 16,
    parameter int N_STAGES = 3,
    parameter int DECIM    = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic [IWIDTH-1:0] in_i,
    input  logic [IWIDTH-1:0] in_q,
    output logic [OWIDTH-1:0] out_i,
    output logic [OWIDTH-1:0] out_q,
    output logic              out_valid
);

    localparam int                C_CNT_W    = clog2(DECIM);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DECIM - 1);

    logic [C_CNT_W-1:0] dec_cnt_q;
    logic [C_CNT_W-1:0] dec_cnt_d;
    logic               out_valid_q;
    logic               out_valid_d;
    logic               w_strobe;

    // DECIM is a power of two, so the counter wraps to zero on its own.
    always_comb begin
        w_strobe    = clk_en && (dec_cnt_q == C_CNT_LAST);
        dec_cnt_d   = clk_en ? dec_cnt_q + C_CNT_W'(1) : dec_cnt_q;
        out_valid_d = w_strobe;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dec_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            dec_cnt_q   <= dec_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    cic_channel #(
        .IWIDTH  (IWIDTH),
        .OWIDTH  (OWIDTH),
        .N_STAGES(N_STAGES),
        .DECIM   (DECIM)
    ) u_chan_i (
        .clock  (clock),
        .reset_n(reset_n),
        .clk_en (clk_en),
        .strobe (w_strobe),
        .sample (in_i),
        .dout   (out_i)
    );

    cic_channel #(
        .IWIDTH  (IWIDTH),
        .OWIDTH  (OWIDTH),
        .N_STAGES(N_STAGES),
        .DECIM   (DECIM)
    ) u_chan_q (
        .clock  (clock),
        .reset_n(reset_n),
        .clk_en (clk_en),
        .strobe (w_strobe),
        .sample (in_q),
        .dout   (out_q)
    );

    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_cic_decimator.sv
//------------------------------------------------------------------------------
// Module  : tb_cic_decimator
// Brief   : Scoreboard bench for cic_decimator; expectations come from a direct
//           FIR form of the CIC (cascaded boxcar taps) or hand-derived constants.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cic_decimator;

    localparam int IWIDTH   = 17;
    localparam int OWIDTH   = 16;
    localparam int N_STAGES = 3;
    localparam int DECIM    = 16;
    localparam int NTAP     = N_STAGES * (DECIM - 1) + 1;
    localparam int DLY      = N_STAGES;
    localparam int SHIFT    = 13;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              clk_en;
    logic [IWIDTH-1:0] in_i;
    logic [IWIDTH-1:0] in_q;
    logic [OWIDTH-1:0] out_i;
    logic [OWIDTH-1:0] out_q;
    logic              out_valid;

    always #5 clock = ~clock;

    cic_decimator #(
        .IWIDTH  (IWIDTH),
        .OWIDTH  (OWIDTH),
        .N_STAGES(N_STAGES),
        .DECIM   (DECIM)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .clk_en   (clk_en),
        .in_i     (in_i),
        .in_q     (in_q),
        .out_i    (out_i),
        .out_q    (out_q),
        .out_valid(out_valid)
    );

    typedef struct {
        int i;
        int q;
    } exp_t;

    exp_t sb[$];
    int   hist_i[$];
    int   hist_q[$];
    int   h[NTAP];
    int   checks = 0;
    int   errors = 0;
    bit   hand_en = 1'b0;
    int   hand_i  = 0;
    int   hand_q  = 0;
    int   en_cnt  = 0;
    bit   prev_valid = 1'b0;

    // Direct FIR: CIC output for the sample at the newest history index.
    function automatic int fir_out(input bit use_q);
        longint acc;
        int     n;
        int     idx;
        acc = 0;
        n   = hist_i.size() - 1;
        for (int j = 0; j < NTAP; j++) begin
            idx = n - DLY - j;
            if (idx >= 0) begin
                acc += longint'(h[j]) * longint'(use_q ? hist_q[idx] : hist_i[idx]);
            end
        end
        return int'(acc >>> SHIFT);
    endfunction

    task automatic step(input bit en, input int vi, input int vq);
        exp_t e;
        clk_en = en;
        in_i   = vi[IWIDTH-1:0];
        in_q   = vq[IWIDTH-1:0];
        if (en && reset_n) begin
            hist_i.push_back(vi);
            hist_q.push_back(vq);
            if (hist_i.size() % DECIM == 0) begin
                if (hand_en && (hist_i.size() / DECIM) >= 4) begin
                    e.i = hand_i;
                    e.q = hand_q;
                end else begin
                    e.i = fir_out(1'b0);
                    e.q = fir_out(1'b1);
                end
                sb.push_back(e);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        clk_en  = 1'b1;
        in_i    = IWIDTH'($urandom);
        in_q    = IWIDTH'($urandom);
        hist_i.delete();
        hist_q.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        clk_en  = 1'b0;
        checks++;
        if (out_i !== '0 || out_q !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_%s: got i=%0d q=%0d v=%b, want 0 0 0",
                     tag, $signed(out_i), $signed(out_q), out_valid);
        end
    endtask

    // Monitor: checks each valid against the scoreboard and its spacing.
    always @(negedge clock) begin
        if (out_valid === 1'b1) begin
            checks++;
            if (prev_valid) begin
                errors++;
                $display("FAIL valid_width: out_valid high on 2 consecutive clocks");
            end
            checks++;
            if (en_cnt != DECIM) begin
                errors++;
                $display("FAIL valid_spacing: got %0d enabled cycles, want %0d", en_cnt, DECIM);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got i=%0d q=%0d, want no output",
                         $signed(out_i), $signed(out_q));
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (int'($signed(out_i)) != e.i || int'($signed(out_q)) != e.q) begin
                    errors++;
                    $display("FAIL sample: got i=%0d q=%0d, want i=%0d q=%0d",
                             $signed(out_i), $signed(out_q), e.i, e.q);
                end
            end
            en_cnt = 0;
        end
        prev_valid = (out_valid === 1'b1);
        if (reset_n !== 1'b1) begin
            en_cnt = 0;
        end else if (clk_en === 1'b1) begin
            en_cnt++;
        end
    end

    initial begin
        int tmp[NTAP];
        for (int j = 0; j < NTAP; j++) h[j] = (j == 0) ? 1 : 0;
        for (int s = 0; s < N_STAGES; s++) begin
            for (int j = 0; j < NTAP; j++) tmp[j] = 0;
            for (int a = 0; a < NTAP; a++) begin
                for (int b = 0; b < DECIM; b++) begin
                    if (a + b < NTAP) tmp[a+b] += h[a];
                end
            end
            h = tmp;
        end

        reset_n = 1'b0;
        clk_en  = 1'b0;
        in_i    = '0;
        in_q    = '0;
        repeat (2) @(posedge clock);
        do_reset("init");

        // DC: 1000 * 16^3 / 2^13 = 500
        hand_en = 1'b1; hand_i = 500; hand_q = -500;
        for (int k = 0; k < 100; k++) step(1'b1, 1000, -1000);

        // Full scale: truncation gives -32768 and floor(32767.5) = 32767
        do_reset("fullscale");
        hand_i = -32768; hand_q = 32767;
        for (int k = 0; k < 200; k++) step(1'b1, -65536, 65535);

        // Gated enable; disabled cycles carry junk that must be ignored
        do_reset("gated");
        hand_i = 500; hand_q = -500;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 1) == 1) step(1'b1, 1000, -1000);
            else step(1'b0, int'($urandom_range(0, 131071)) - 65536, int'($urandom));
        end

        // Reset mid-frame at dec_cnt = 7
        do_reset("midpre");
        hand_en = 1'b0;
        for (int k = 0; k < 3 * DECIM + 7; k++) step(1'b1, 1000, -1000);
        do_reset("midframe");
        for (int k = 0; k < 40; k++) step(1'b1, 1000, -1000);

        // Impulse responses
        do_reset("impulse");
        step(1'b1, 1, 0);
        for (int k = 0; k < 80; k++) step(1'b1, 0, 0);
        do_reset("impulse_big");
        step(1'b1, 30000, -30000);
        for (int k = 0; k < 80; k++) step(1'b1, 0, 0);

        // Random mixer-style stream with occasional enable gaps
        do_reset("tone");
        for (int k = 0; k < 10000; k++) begin
            step($urandom_range(0, 7) != 0,
                 int'($urandom_range(0, 131071)) - 65536,
                 int'($urandom_range(0, 131071)) - 65536);
        end

        for (int k = 0; k < 20; k++) step(1'b0, 0, 0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outputs outstanding, want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
